digit_scan_mux: RTL

//  Time-multiplexed scanner for a common-anode multi-digit 7-segment display.

---
 rtl/disp_pkg.sv | 20 ++
 rtl/refresh_prescaler.sv | 41 ++++
 rtl/digit_scan_mux.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared constants and helpers for the multiplexed 7-segment display blocks.
//   NIBBLE_W       : bits per displayed hex digit
//   SEG_W          : segment count of the downstream decoder output
//   DEF_NUM_DIGITS : default digit count for display scanners
//   idx_width()    : width of a digit index for a given digit count
// ---------------------------------------------------------------------------
package disp_pkg;

  localparam int NIBBLE_W       = 4;
  localparam int SEG_W          = 7;
  localparam int DEF_NUM_DIGITS = 4;

  // A single-digit display still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// ---------------------------------------------------------------------------
// refresh_prescaler
// Generic modulo-DIV counter. cnt runs 0..DIV-1 and wraps; tick is high
// while cnt sits at its last value, so the wrap and the tick share one edge.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-low reset (cnt -> 0)
//   cnt  out  current count, CNT_W bits
//   tick out  1 when cnt == DIV-1
// ---------------------------------------------------------------------------
module refresh_prescaler #(
  parameter int DIV   = 50000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt  = r_cnt;
  assign tick = w_tick;

endmodule

// File: rtl/digit_scan_mux.sv
// ---------------------------------------------------------------------------
// digit_scan_mux
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Steps through the nibbles of a double-buffered hex value one digit slot at
// a time, with a short all-off guard at the start of each slot, optional
// leading-zero blanking, and a pulse on every frame wrap.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   load         in   strobe: capture value_in into the pending buffer
//   value_in     in   packed digits, nibble 0 = rightmost digit
//   blank_lz     in   1 = blank leading zeros (level)
//   digit_nibble out  nibble for the downstream hex-to-7-segment decoder
//   digit_en     out  active-low digit enables (one low, or all high)
//   digit_blank  out  1 = segments must be forced off this cycle
//   frame_done   out  one-cycle pulse when the scan wraps back to digit 0
// ---------------------------------------------------------------------------
module digit_scan_mux
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2,
  parameter int CNT_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
  input  logic                           blank_lz,
  output logic [NIBBLE_W-1:0]            digit_nibble,
  output logic [NUM_DIGITS-1:0]          digit_en,
  output logic                           digit_blank,
  output logic                           frame_done
);

  localparam int                IDX_W    = idx_width(NUM_DIGITS);
  localparam int                VAL_W    = NIBBLE_W * NUM_DIGITS;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]  GUARD_C  = CNT_W'(GUARD);

  generate
    if ((NUM_DIGITS < 2) || (GUARD < 0) || (REFRESH_DIV < GUARD + 2) ||
        ((CNT_W < 31) && (REFRESH_DIV > (1 << CNT_W)))) begin : g_bad_params
      $error("digit_scan_mux: illegal NUM_DIGITS/REFRESH_DIV/GUARD/CNT_W combination");
    end
  endgenerate

  // Digit i (i>0) is blanked when it and every digit above it are zero.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [VAL_W-1:0] val,
                                                   input logic            enable);
    logic zero_above;
    lz_mask    = '0;
    zero_above = enable;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (val[i*NIBBLE_W +: NIBBLE_W] == '0);
      lz_mask[i] = zero_above;
    end
  endfunction

  logic [CNT_W-1:0]      w_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_tick;
  logic                  w_boundary;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [VAL_W-1:0]      r_active;
  logic [VAL_W-1:0]      w_active_nxt;
  logic [VAL_W-1:0]      r_pend;
  logic                  r_pend_v;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [NIBBLE_W-1:0]   w_nib_nxt;
  logic                  w_slot_blank;
  logic                  w_blank_nxt;
  logic [NUM_DIGITS-1:0] w_en_nxt;
  logic [NIBBLE_W-1:0]   r_nibble;
  logic [NUM_DIGITS-1:0] r_en;
  logic                  r_blank;
  logic                  r_frame_done;

  refresh_prescaler #(
    .DIV   (REFRESH_DIV),
    .CNT_W (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .cnt  (w_cnt),
    .tick (w_tick)
  );

  // Outputs are registered from the next-state view, so mirror the wrap here.
  assign w_cnt_nxt  = w_tick ? '0 : w_cnt + CNT_W'(1);
  assign w_boundary = w_tick & (r_idx == LAST_IDX);

  // ---- digit index FSM: linear walk 0..NUM_DIGITS-1, advancing on tick ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= '0;
    end else begin
      r_idx <= w_idx_nxt;
    end
  end

  always_comb begin
    w_idx_nxt = r_idx;
    if (w_tick) begin
      w_idx_nxt = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
    end
  end

  // ---- active/pending double buffer; active only changes on a frame wrap ----
  always_comb begin
    w_active_nxt = r_active;
    if (w_boundary) begin
      if (load) begin
        w_active_nxt = value_in;
      end else if (r_pend_v) begin
        w_active_nxt = r_pend;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      if (load) begin
        r_pend <= value_in;
      end
      if (w_boundary) begin
        r_pend_v <= 1'b0;
      end else if (load) begin
        r_pend_v <= 1'b1;
      end
    end
  end

  // ---- output decode for the slot the next edge enters ----
  assign w_lz = lz_mask(w_active_nxt, blank_lz);

  always_comb begin
    w_nib_nxt    = '0;
    w_slot_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nxt == IDX_W'(i)) begin
        w_nib_nxt    = w_active_nxt[i*NIBBLE_W +: NIBBLE_W];
        w_slot_blank = w_lz[i];
      end
    end
    w_blank_nxt = (w_cnt_nxt < GUARD_C) | w_slot_blank;
    w_en_nxt    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((w_idx_nxt == IDX_W'(i)) && !w_blank_nxt) begin
        w_en_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_nibble     <= '0;
      r_en         <= '1;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_nibble     <= w_nib_nxt;
      r_en         <= w_en_nxt;
      r_blank      <= w_blank_nxt;
      r_frame_done <= w_boundary;
    end
  end

  assign digit_nibble = r_nibble;
  assign digit_en     = r_en;
  assign digit_blank  = r_blank;
  assign frame_done   = r_frame_done;

endmodule
